// File: rtl/alu_seq_pkg.sv
// Opcodes, FSM states and the queued command record for alu_cmd_sequencer.
// ALU_SEQ_CHAIN_EN adds a chain flag to the command record.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } seq_state_e;

   typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
      logic       chain;
`endif
      logic [1:0] a;
      logic [1:0] b;
      logic [2:0] sel;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: pointer-plus-count, pointers wrap modulo DEPTH (power of two).
module alu_cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = CMD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues {A,B,ALU_Sel} commands, issues them one at a time to the external ALU
// and captures Result/Carry plus flags. ALU_SEQ_CHAIN_EN enables result chaining.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_A,
   input  logic [1:0] cmd_B,
   input  logic [2:0] cmd_Sel,
`ifdef ALU_SEQ_CHAIN_EN
   input  logic       cmd_chain,
`endif
   output logic [1:0] A,
   output logic [1:0] B,
   output logic [2:0] ALU_Sel,
   input  logic [1:0] Result,
   input  logic       Carry,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_Result,
   output logic       rsp_Carry,
   output logic       rsp_Zero,
   output logic       rsp_Err
);

   seq_state_e state_q, state_d;
   logic [1:0] a_q, a_d, b_q, b_d;
   logic [2:0] sel_q, sel_d;
   logic       err_q, err_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [1:0] rsp_result_q, rsp_result_d;
   logic       rsp_carry_q, rsp_carry_d;
   logic       rsp_zero_q, rsp_zero_d;
   logic       rsp_err_q, rsp_err_d;
   logic       ready_q, ready_d;
`ifdef ALU_SEQ_CHAIN_EN
   logic [1:0] last_q, last_d;
`endif

   cmd_t       push_cmd, head_cmd;
   logic       fifo_full, fifo_empty;
   logic       push, pop;
   logic [1:0] issue_a;

   // ready_q keeps cmd_ready low until the first edge after reset release
   assign cmd_ready = ready_q & ~fifo_full;
   assign push      = cmd_valid & cmd_ready;

   always_comb begin
      push_cmd     = '0;
      push_cmd.a   = cmd_A;
      push_cmd.b   = cmd_B;
      push_cmd.sel = cmd_Sel;
`ifdef ALU_SEQ_CHAIN_EN
      push_cmd.chain = cmd_chain;
`endif
   end

`ifdef ALU_SEQ_CHAIN_EN
   assign issue_a = head_cmd.chain ? last_q : head_cmd.a;
`else
   assign issue_a = head_cmd.a;
`endif

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      sel_d        = sel_q;
      err_d        = err_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      ready_d      = 1'b1;
      pop          = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      last_d       = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               a_d     = issue_a;
               b_d     = head_cmd.b;
               sel_d   = head_cmd.sel;
               err_d   = ~is_legal_op(head_cmd.sel);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_result_d = Result;
            rsp_carry_d  = Carry;
            rsp_zero_d   = (Result == 2'b00);
            rsp_err_d    = err_q;
            rsp_valid_d  = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
            last_d       = Result;
`endif
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  a_d     = issue_a;
                  b_d     = head_cmd.b;
                  sel_d   = head_cmd.sel;
                  err_d   = ~is_legal_op(head_cmd.sel);
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= '0;
         err_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         ready_q      <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
         last_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sel_q        <= sel_d;
         err_q        <= err_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         ready_q      <= ready_d;
`ifdef ALU_SEQ_CHAIN_EN
         last_q       <= last_d;
`endif
      end
   end

   assign A          = a_q;
   assign B          = b_q;
   assign ALU_Sel    = sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_Result = rsp_result_q;
   assign rsp_Carry  = rsp_carry_q;
   assign rsp_Zero   = rsp_zero_q;
   assign rsp_Err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a reference 2-bit ALU beside it.
// Chained-result steps run only when ALU_SEQ_CHAIN_EN is defined.
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [1:0] res;
      logic       c;
      logic       z;
      logic       e;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_A;
   logic [1:0] cmd_B;
   logic [2:0] cmd_Sel;
`ifdef ALU_SEQ_CHAIN_EN
   logic       cmd_chain;
`endif
   logic [1:0] A;
   logic [1:0] B;
   logic [2:0] ALU_Sel;
   logic [1:0] Result;
   logic       Carry;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [1:0] rsp_Result;
   logic       rsp_Carry;
   logic       rsp_Zero;
   logic       rsp_Err;

   int         n_vec = 0;
   int         n_err = 0;
   exp_t       exp_q[$];
   logic [1:0] last_exp = 2'b00;

   alu_cmd_sequencer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_A      (cmd_A),
      .cmd_B      (cmd_B),
      .cmd_Sel    (cmd_Sel),
`ifdef ALU_SEQ_CHAIN_EN
      .cmd_chain  (cmd_chain),
`endif
      .A          (A),
      .B          (B),
      .ALU_Sel    (ALU_Sel),
      .Result     (Result),
      .Carry      (Carry),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_Result (rsp_Result),
      .rsp_Carry  (rsp_Carry),
      .rsp_Zero   (rsp_Zero),
      .rsp_Err    (rsp_Err)
   );

   // {carry/borrow, result} of the 2-bit ALU
   function automatic logic [2:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                          input logic [2:0] sel);
      logic [2:0] r;
      case (sel)
         3'b000:  r = {1'b0, a} + {1'b0, b};
         3'b001:  r = {1'b0, a} - {1'b0, b};
         3'b010:  r = {1'b0, a & b};
         3'b011:  r = {1'b0, a | b};
         3'b100:  r = {1'b0, a ^ b};
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   always_comb {Carry, Result} = alu_ref(A, B, ALU_Sel);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic do_push(input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel,
                          input logic [1:0] model_a);
      logic [2:0] r;
      exp_t       e;
      cmd_A     = a;
      cmd_B     = b;
      cmd_Sel   = sel;
      cmd_valid = 1'b1;
      for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) @(negedge clk);
      chk("push_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      r     = alu_ref(model_a, b, sel);
      e.res = r[1:0];
      e.c   = r[2];
      e.z   = (r[1:0] == 2'b00);
      e.e   = (sel > 3'b100);
      exp_q.push_back(e);
      last_exp = r[1:0];
   endtask

   task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel);
`ifdef ALU_SEQ_CHAIN_EN
      cmd_chain = 1'b0;
`endif
      do_push(a, b, sel, a);
   endtask

`ifdef ALU_SEQ_CHAIN_EN
   task automatic push_ch(input logic [1:0] b, input logic [2:0] sel);
      cmd_chain = 1'b1;
      do_push(2'b00, b, sel, last_exp);
      cmd_chain = 1'b0;
   endtask
`endif

   // Waits for a response, compares it with the scoreboard head, then consumes it.
   task automatic check_rsp(input string tag);
      exp_t e;
      for (int n = 0; n < 50 && rsp_valid !== 1'b1; n++) @(negedge clk);
      chk({tag, "_valid"}, rsp_valid, 1'b1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      chk({tag, "_result"}, rsp_Result, e.res);
      chk({tag, "_carry"},  rsp_Carry,  e.c);
      chk({tag, "_zero"},   rsp_Zero,   e.z);
      chk({tag, "_err"},    rsp_Err,    e.e);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [2:0] ops [5];
      exp_t       hd;
      ops[0] = OP_ADD;
      ops[1] = OP_SUB;
      ops[2] = OP_AND;
      ops[3] = OP_OR;
      ops[4] = OP_XOR;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_A     = '0;
      cmd_B     = '0;
      cmd_Sel   = '0;
      rsp_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      cmd_chain = 1'b0;
`endif

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_operands", {A, B, ALU_Sel}, 8'h00);
      chk("rst_rsp", {rsp_Result, rsp_Carry, rsp_Zero, rsp_Err}, 8'h00);
      rst = 1'b0;
      #1;
      chk("rel_ready_before_edge", cmd_ready, 1'b0);
      @(negedge clk);
      chk("rel_ready_after_edge", cmd_ready, 1'b1);

      // single ADD 3+2, two-cycle latency
      rsp_ready = 1'b1;
      push(2'd3, 2'd2, OP_ADD);
      chk("add_lat0", rsp_valid, 1'b0);
      @(negedge clk);
      chk("add_lat1", rsp_valid, 1'b0);
      chk("add_issue", {A, B, ALU_Sel}, {2'd3, 2'd2, OP_ADD});
      @(negedge clk);
      chk("add_lat2", rsp_valid, 1'b1);
      check_rsp("add_3_2");

      // subtraction with and without borrow
      push(2'd1, 2'd2, OP_SUB);
      check_rsp("sub_1_2");
      push(2'd2, 2'd2, OP_SUB);
      check_rsp("sub_2_2");

      // illegal opcode followed by a legal XOR
      push(2'd3, 2'd3, 3'b110);
      push(2'd2, 2'd3, OP_XOR);
      check_rsp("illegal_110");
      check_rsp("xor_2_3");

      // back-pressure: one issued plus DEPTH queued
      rsp_ready = 1'b0;
      for (int unsigned i = 0; i < DEPTH + 1; i++) begin
         chk($sformatf("bp_ready_%0d", i), cmd_ready, 1'b1);
         push(2'(i), 2'(3 - (i % 4)), ops[i % 5]);
      end
      chk("bp_full", cmd_ready, 1'b0);
      for (int n = 0; n < 50 && rsp_valid !== 1'b1; n++) @(negedge clk);
      hd = exp_q[0];
      chk("bp_hold_valid0", rsp_valid, 1'b1);
      chk("bp_hold_result0", {rsp_Result, rsp_Carry}, {hd.res, hd.c});
      repeat (3) @(negedge clk);
      chk("bp_hold_valid1", rsp_valid, 1'b1);
      chk("bp_hold_result1", {rsp_Result, rsp_Carry, rsp_Zero, rsp_Err}, {hd.res, hd.c, hd.z, hd.e});
      chk("bp_still_full", cmd_ready, 1'b0);
      for (int unsigned i = 0; i < DEPTH + 1; i++) check_rsp($sformatf("bp_drain_%0d", i));
      chk("bp_sb_empty", 8'(exp_q.size()), 8'd0);

      // reset while EXEC with two commands queued
      push(2'd1, 2'd1, OP_ADD);
      push(2'd3, 2'd1, OP_SUB);
      push(2'd2, 2'd2, OP_OR);
      push(2'd1, 2'd3, OP_AND);
      check_rsp("pre_rst");
      chk("pre_rst_exec_valid", rsp_valid, 1'b0);
      chk("pre_rst_exec_issue", {A, B, ALU_Sel}, {2'd3, 2'd1, OP_SUB});
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", cmd_ready, 1'b0);
      chk("mid_rst_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      last_exp = 2'b00;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1'b1);
      chk("post_rst_operands", {A, B, ALU_Sel}, 8'h00);
      for (int n = 0; n < 6; n++) begin
         chk($sformatf("no_stale_%0d", n), rsp_valid, 1'b0);
         @(negedge clk);
      end
      push(2'd2, 2'd1, OP_SUB);
      check_rsp("post_rst_sub");

`ifdef ALU_SEQ_CHAIN_EN
      // chaining from the last captured result
      push(2'd1, 2'd1, OP_ADD);
      push_ch(2'd1, OP_ADD);
      push_ch(2'd0, OP_OR);
      check_rsp("chain_base");
      check_rsp("chain_add");
      check_rsp("chain_or");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
